// File: rtl/multiplication.sv
// Sequential unsigned shift-and-add multiplier.
// Operands are accepted over a valid/ready handshake. One multiplier bit
// is consumed per clock. The 2*WIDTH-bit product is then offered over a
// second valid/ready handshake. Latency is fixed at WIDTH iteration edges.
module multiplication #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   output logic                 busy,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   Res
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t               state_q;
   logic [WIDTH-1:0]     mc_q;
   logic [WIDTH:0]       hi_q;
   logic [WIDTH-1:0]     lo_q;
   logic [CNT_W-1:0]     cnt_q;
   logic                 in_ready_q;
   logic                 busy_q;
   logic                 out_valid_q;
   logic [2*WIDTH-1:0]   res_q;

   logic [WIDTH:0]       sum_d;
   logic [WIDTH:0]       hi_d;
   logic [WIDTH-1:0]     lo_d;
   logic [2*WIDTH-1:0]   prod_d;

   // One iteration: conditionally add the multiplicand into the upper half
   // (carry kept in bit WIDTH), then shift {hi,lo} right by one.
   always_comb begin
      sum_d = hi_q;
      if (lo_q[0]) begin
         sum_d = hi_q + {1'b0, mc_q};
      end else begin
         sum_d = hi_q;
      end
      hi_d   = {1'b0, sum_d[WIDTH:1]};
      lo_d   = {sum_d[0], lo_q[WIDTH-1:1]};
      prod_d = {hi_d[WIDTH-1:0], lo_d};
   end

   // Control FSM and datapath registers; all handshake outputs are registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         mc_q        <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
         res_q       <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid && in_ready_q) begin
                  mc_q       <= A;
                  hi_q       <= '0;
                  lo_q       <= B;
                  cnt_q      <= '0;
                  state_q    <= RUN;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end else begin
                  state_q    <= IDLE;
               end
            end
            RUN: begin
               hi_q  <= hi_d;
               lo_q  <= lo_d;
               cnt_q <= cnt_q + CNT_W'(1);
               // Final iteration: latch the product and leave RUN on the same edge.
               if (cnt_q == LAST_CNT) begin
                  res_q       <= prod_d;
                  state_q     <= DONE;
                  busy_q      <= 1'b0;
                  out_valid_q <= 1'b1;
               end else begin
                  state_q     <= RUN;
               end
            end
            DONE: begin
               // No new operand is taken on the handshake edge; IDLE accepts next edge.
               if (out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end else begin
                  state_q     <= DONE;
               end
            end
            default: begin
               state_q     <= IDLE;
               in_ready_q  <= 1'b1;
               busy_q      <= 1'b0;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign busy      = busy_q;
   assign out_valid = out_valid_q;
   assign Res       = res_q;

endmodule

// File: tb/tb_multiplication.sv
// Scoreboard bench for the shift-and-add multiplier.
// An 8-bit instance gets directed latency/handshake/reset tests plus a
// random sweep; a 16-bit instance gets a concurrent random sweep.
module tb_multiplication;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n8, in_valid8, in_ready8, busy8, out_valid8, out_ready8;
   logic [7:0]  A8, B8;
   logic [15:0] Res8;
   logic        rst_n16, in_valid16, in_ready16, busy16, out_valid16, out_ready16;
   logic [15:0] A16, B16;
   logic [31:0] Res16;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit done8 = 1'b0;
   bit done16 = 1'b0;
   logic [15:0] exp8[$];
   logic [31:0] exp16[$];

   multiplication #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n8), .in_valid(in_valid8), .in_ready(in_ready8),
      .A(A8), .B(B8), .busy(busy8), .out_valid(out_valid8),
      .out_ready(out_ready8), .Res(Res8));

   multiplication #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n16), .in_valid(in_valid16), .in_ready(in_ready16),
      .A(A16), .B(B16), .busy(busy16), .out_valid(out_valid16),
      .out_ready(out_ready16), .Res(Res16));

   // Edge counter used to measure accept-to-accept spacing.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %0d required %0d", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard for the 8-bit instance: push on input handshake, pop on output handshake.
   always @(negedge clk) begin
      if (rst_n8 && in_valid8 && in_ready8) exp8.push_back(16'(A8) * 16'(B8));
      if (rst_n8 && out_valid8 && out_ready8) begin
         if (exp8.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL res8: product %0d presented with no operation outstanding", Res8);
         end else begin
            chk("res8", 64'(Res8), 64'(exp8.pop_front()));
         end
      end
   end

   // Scoreboard for the 16-bit instance.
   always @(negedge clk) begin
      if (rst_n16 && in_valid16 && in_ready16) exp16.push_back(32'(A16) * 32'(B16));
      if (rst_n16 && out_valid16 && out_ready16) begin
         if (exp16.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL res16: product %0d presented with no operation outstanding", Res16);
         end else begin
            chk("res16", 64'(Res16), 64'(exp16.pop_front()));
         end
      end
   end

   // One directed operation on the 8-bit instance with timing measurements.
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit garbage,
                      input int hold, output int acc_edge, output int lat, output int busy_n);
      int ir_bad;
      int hold_bad;
      logic [15:0] r0;
      A8 = a; B8 = b; in_valid8 = 1'b1; out_ready8 = 1'b0;
      step();
      acc_edge = cyc;
      if (garbage) begin
         A8 = 8'hFF; B8 = 8'hFF;
      end else begin
         in_valid8 = 1'b0;
      end
      lat = 0; busy_n = 0; ir_bad = 0;
      while (!out_valid8 && lat < 40) begin
         if (busy8) busy_n++;
         if (in_ready8) ir_bad++;
         step();
         lat++;
      end
      if (in_ready8) ir_bad++;
      hold_bad = 0;
      r0 = Res8;
      for (int i = 0; i < hold; i++) begin
         step();
         if (Res8 !== r0 || !out_valid8 || in_ready8) hold_bad++;
      end
      chk("in_ready_low", 64'(ir_bad), 64'd0);
      if (hold > 0) chk("backpressure_hold", 64'(hold_bad), 64'd0);
      in_valid8 = 1'b0; out_ready8 = 1'b1;
      step();
      chk("out_valid_drop", 64'(out_valid8), 64'd0);
      chk("idle_in_ready", 64'(in_ready8), 64'd1);
      out_ready8 = 1'b0;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n8 = 1'b0; in_valid8 = 1'b0; out_ready8 = 1'b0; A8 = 8'd0; B8 = 8'd0;
      rst_n16 = 1'b0; in_valid16 = 1'b0; out_ready16 = 1'b0; A16 = 16'd0; B16 = 16'd0;
      repeat (3) step();
      chk("rst_in_ready8", 64'(in_ready8), 64'd1);
      chk("rst_busy8", 64'(busy8), 64'd0);
      chk("rst_out_valid8", 64'(out_valid8), 64'd0);
      chk("rst_res8", 64'(Res8), 64'd0);
      chk("rst_in_ready16", 64'(in_ready16), 64'd1);
      chk("rst_res16", 64'(Res16), 64'd0);
      @(negedge clk);
      #1;
      rst_n8 = 1'b1; rst_n16 = 1'b1;
      step();
      fork
         begin : branch8
            int e1, e2, lat, bn, acc, g;
            // Max operands: latency and busy width.
            op8(8'd255, 8'd255, 1'b0, 0, e1, lat, bn);
            chk("max_latency", 64'(lat), 64'd8);
            chk("max_busy_cycles", 64'(bn), 64'd8);
            // Zero operands, back to back.
            op8(8'd0, 8'hA5, 1'b0, 0, e1, lat, bn);
            chk("zero_a_latency", 64'(lat), 64'd8);
            op8(8'h5A, 8'd0, 1'b0, 0, e2, lat, bn);
            chk("zero_b_latency", 64'(lat), 64'd8);
            chk("accept_spacing", 64'(e2 - e1), 64'd10);
            // Operand isolation with in_valid and garbage held during RUN/DONE.
            op8(8'd13, 8'd11, 1'b1, 0, e1, lat, bn);
            chk("isolation_latency", 64'(lat), 64'd8);
            // Backpressure for 5 cycles.
            op8(8'd200, 8'd3, 1'b0, 5, e1, lat, bn);
            chk("backpressure_res", 64'(Res8), 64'd600);
            // Reset after 3 iterations aborts the operation.
            A8 = 8'd7; B8 = 8'd9; in_valid8 = 1'b1;
            step();
            in_valid8 = 1'b0;
            repeat (3) step();
            rst_n8 = 1'b0;
            #1;
            chk("abort_out_valid", 64'(out_valid8), 64'd0);
            chk("abort_res", 64'(Res8), 64'd0);
            chk("abort_in_ready", 64'(in_ready8), 64'd1);
            chk("abort_busy", 64'(busy8), 64'd0);
            exp8.delete();
            @(negedge clk);
            #1;
            rst_n8 = 1'b1;
            step();
            op8(8'd7, 8'd9, 1'b0, 0, e1, lat, bn);
            chk("post_reset_latency", 64'(lat), 64'd8);
            // Random sweep with input and output stalls.
            fork
               begin
                  for (int n = 0; n < 1000; n++) begin
                     in_valid8 = 1'b0;
                     repeat ($urandom % 3) step();
                     A8 = 8'($urandom); B8 = 8'($urandom); in_valid8 = 1'b1;
                     acc = 0; g = 0;
                     while (acc == 0 && g < 200) begin
                        acc = int'(in_ready8);
                        step();
                        g++;
                     end
                     chk("accept8", 64'(acc), 64'd1);
                     in_valid8 = 1'b0;
                     A8 = 8'($urandom); B8 = 8'($urandom);
                  end
                  done8 = 1'b1;
               end
               begin
                  while (!done8) begin
                     out_ready8 = (($urandom % 4) != 0);
                     step();
                  end
               end
            join
            out_ready8 = 1'b1;
            g = 0;
            while (exp8.size() != 0 && g < 100) begin
               step();
               g++;
            end
            chk("drain8", 64'(exp8.size()), 64'd0);
         end
         begin : branch16
            int acc, g;
            bit stop16;
            stop16 = 1'b0;
            fork
               begin
                  for (int n = 0; n < 1000; n++) begin
                     in_valid16 = 1'b0;
                     repeat ($urandom % 3) step();
                     A16 = 16'($urandom); B16 = 16'($urandom); in_valid16 = 1'b1;
                     acc = 0; g = 0;
                     while (acc == 0 && g < 300) begin
                        acc = int'(in_ready16);
                        step();
                        g++;
                     end
                     chk("accept16", 64'(acc), 64'd1);
                     in_valid16 = 1'b0;
                     A16 = 16'($urandom); B16 = 16'($urandom);
                  end
                  stop16 = 1'b1;
               end
               begin
                  while (!stop16) begin
                     out_ready16 = (($urandom % 4) != 0);
                     step();
                  end
               end
            join
            out_ready16 = 1'b1;
            g = 0;
            while (exp16.size() != 0 && g < 100) begin
               step();
               g++;
            end
            chk("drain16", 64'(exp16.size()), 64'd0);
            done16 = 1'b1;
         end
      join
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/multiplication.md
# multiplication

Sequential unsigned shift-and-add multiplier. It is the inverse arithmetic partner of the team's restoring divider and shares the same generic `WIDTH` operand convention. It takes two `WIDTH`-bit operands over a valid/ready handshake and computes one multiplier bit per clock. It then presents the full `2*WIDTH`-bit product over a second valid/ready handshake, so datapaths can form `A*B` and recover operands with the divider.

## Interface
- `WIDTH`, default 8, operand width in bits (≥2); product is `2*WIDTH` bits.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `in_valid`  input  1  operands `A`, `B` are valid.
- `in_ready`  output  1  block can accept operands (high only in IDLE).
- `A`  input  `WIDTH`  multiplicand, unsigned.
- `B`  input  `WIDTH`  multiplier, unsigned.
- `busy`  output  1  high while in RUN.
- `out_valid`  output  1  `Res` holds a completed product.
- `out_ready`  input  1  consumer accepts `Res`.
- `Res`  output  `2*WIDTH`  product `A*B`, unsigned.

## Operation
- **States**
  - IDLE: `in_ready`=1.
  - RUN: `busy`=1.
  - DONE: `out_valid`=1.
- **IDLE → RUN** on a rising edge with `in_valid && in_ready`.
  - Capture `A` into the multiplicand register `mc`.
  - Load the product register as `hi`=0 (`WIDTH+1` bits) and `lo`=`B` (`WIDTH` bits).
  - Clear the iteration counter (`$clog2(WIDTH+1)` bits).
- **RUN** (each edge): one iteration.
  - If `lo[0]`=1, then `hi` = `hi + {1'b0,mc}`, computed in `WIDTH+1` bits so the carry is kept.
  - Shift `{hi,lo}` right by 1 with 0 into the MSB.
  - Increment the counter.
  - On the `WIDTH`-th iteration edge, perform the final iteration and move to DONE on the same edge.
- **Product format**: `Res` = `{hi[WIDTH-1:0], lo}`. `hi[WIDTH]` is always 0 after the final shift.
- **Fixed latency**: no early termination on zero operands or zero multiplier bits.
- **DONE → IDLE** on an edge with `out_ready`=1.
  - `Res` keeps its last value until the next operation loads.
- **Operand capture**: `A` and `B` are sampled only on the accepting edge. Changes during RUN or DONE have no effect.
- **`in_valid` outside IDLE**: ignored, since `in_ready`=0. Upstream must hold its operands until it sees `in_ready`.
- **No overlap**: a new operation cannot be accepted on the same edge as the DONE handshake.
- **Undefined `in_valid`/`out_ready` in IDLE/RUN**: `out_ready` is don't-care outside DONE.

## Timing
- **Reset values** (asynchronous, immediate on `rst_n`=0)
  - State = IDLE, `in_ready`=1, `busy`=0, `out_valid`=0, `Res`=0.
  - Counter, `mc`, `hi`, `lo` all cleared.
- **Reset mid-RUN or mid-DONE**: the operation is aborted and lost; outputs take their reset values.
  - After `rst_n` rises, the first edge can accept new operands.
- **Latency**: accept on edge E0. `busy` is high from after E0 through E0+`WIDTH`. `out_valid` is high after edge E0+`WIDTH`, which is `WIDTH` edges after acceptance.
- **Throughput** with `out_ready` tied high: one product every `WIDTH+2` edges.
  - The sequence is: accept edge, `WIDTH` iteration edges, a DONE handshake edge returning to IDLE, then the next accept edge.
- **Output handshake**: `out_valid` stays high and `Res` stays stable for as long as `out_ready`=0.
  - `out_valid` falls after the edge where `out_ready`=1.
- **Outputs are registered or decoded from state only**: there is no combinational path from `in_valid`/`out_ready` to any output.

## Test plan
- **Max operands**: `WIDTH`=8, `A`=255, `B`=255, `out_ready`=1 → `Res`=0xFE01 (65025).
  - `out_valid` rises exactly 8 edges after the accept edge.
  - `busy` is high for 8 cycles.
- **Zero operands**: `A`=0, `B`=0xA5, then `A`=0x5A, `B`=0 → `Res`=0 both times.
  - Latency is still 8 edges.
  - The second op is accepted 10 edges after the first.
- **Operand isolation**: `A`=13, `B`=11 accepted, then `A`/`B` driven to 0xFF during RUN → `Res`=143 (0x008F).
  - `in_ready` stays 0 during RUN and DONE even with `in_valid` held high.
- **Backpressure**: `A`=200, `B`=3, `out_ready`=0 for 5 cycles after `out_valid` → `Res`=600 (0x0258), stable all 5 cycles.
  - `in_ready`=0 throughout.
  - IDLE is reached one edge after `out_ready`=1.
- **Reset mid-operation**: accept `A`=7, `B`=9, pulse `rst_n` low after 3 iterations → `out_valid`=0, `Res`=0, `in_ready`=1 immediately.
  - Next op `A`=7, `B`=9 yields 63 with full 8-edge latency.
- **Random sweep**: `WIDTH`=8 and `WIDTH`=16, 1000 random pairs with random `in_valid`/`out_ready` stalls → every `Res` equals `A*B`.
  - No product is dropped or duplicated, checked against a reference queue.
